// File: rtl/dcpu16_pkg.sv
// Shared types and width constants for the DCPU-16 bus fabric.
package dcpu16_pkg;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;

    // Arbiter bus-ownership states
    typedef enum logic [1:0] {
        IDLE,
        BUSF,
        BUSG
    } arb_state_t;

endpackage

// File: rtl/dcpu16_wdog.sv
// Clearable up-counter that flags when a bus transaction has run TOUT cycles.
module dcpu16_wdog #(
    parameter int unsigned TOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expire
);

    localparam int unsigned CW = $clog2(TOUT);
    localparam logic [CW-1:0] LAST = CW'(TOUT - 1);

    logic [CW-1:0] cnt_q;

    // Count while a transaction owns the bus; a new grant restarts from zero.
    // The arbiter leaves the bus on expiry, so the count never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expire = (cnt_q == LAST);

endmodule

// File: rtl/dcpu16_busarb.sv
// Round-robin arbiter sharing one memory bus between the fetch and data ports.
module dcpu16_busarb
    import dcpu16_pkg::*;
#(
    parameter int unsigned TOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_stb,
    input  logic          f_wre,
    input  logic [AW-1:0] f_adr,
    input  logic [DW-1:0] f_dto,
    output logic [DW-1:0] f_dti,
    output logic          f_ack,
    output logic          f_err,
    input  logic          g_stb,
    input  logic          g_wre,
    input  logic [AW-1:0] g_adr,
    input  logic [DW-1:0] g_dto,
    output logic [DW-1:0] g_dti,
    output logic          g_ack,
    output logic          g_err,
    output logic          m_stb,
    output logic          m_wre,
    output logic [AW-1:0] m_adr,
    output logic [DW-1:0] m_dto,
    input  logic [DW-1:0] m_dti,
    input  logic          m_ack
);

    arb_state_t state_q, state_d;
    logic lst_q, lst_d;
    logic grant_f, grant_g, done, expire;

    logic          m_stb_d, m_wre_d;
    logic [AW-1:0] m_adr_d;
    logic [DW-1:0] m_dto_d, f_dti_d, g_dti_d;
    logic          f_ack_d, f_err_d, g_ack_d, g_err_d;

    // Grant decode: fetch wins unless data also requests and fetch was served last.
    assign grant_f = (state_q == IDLE) && f_stb && (!g_stb || lst_q);
    assign grant_g = (state_q == IDLE) && g_stb && !grant_f;
    // A real ack takes priority over a simultaneous watchdog expiry.
    assign done    = (state_q != IDLE) && (m_ack || expire);

    dcpu16_wdog #(
        .TOUT(TOUT)
    ) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (grant_f | grant_g),
        .run   (state_q != IDLE),
        .expire(expire)
    );

    // State register plus all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lst_q   <= 1'b1;
            m_stb   <= 1'b0;
            m_wre   <= 1'b0;
            m_adr   <= '0;
            m_dto   <= '0;
            f_dti   <= '0;
            f_ack   <= 1'b0;
            f_err   <= 1'b0;
            g_dti   <= '0;
            g_ack   <= 1'b0;
            g_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            lst_q   <= lst_d;
            m_stb   <= m_stb_d;
            m_wre   <= m_wre_d;
            m_adr   <= m_adr_d;
            m_dto   <= m_dto_d;
            f_dti   <= f_dti_d;
            f_ack   <= f_ack_d;
            f_err   <= f_err_d;
            g_dti   <= g_dti_d;
            g_ack   <= g_ack_d;
            g_err   <= g_err_d;
        end
    end

    // Next-state: hold the bus until ack or timeout, then return to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_f) begin
                    state_d = BUSF;
                end else if (grant_g) begin
                    state_d = BUSG;
                end
            end
            BUSF, BUSG: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next values: latch the winner on grant, return data and ack on completion.
    always_comb begin
        lst_d   = lst_q;
        m_stb_d = m_stb;
        m_wre_d = m_wre;
        m_adr_d = m_adr;
        m_dto_d = m_dto;
        f_dti_d = f_dti;
        g_dti_d = g_dti;
        f_ack_d = 1'b0;
        f_err_d = 1'b0;
        g_ack_d = 1'b0;
        g_err_d = 1'b0;
        if (grant_f) begin
            m_stb_d = 1'b1;
            m_wre_d = f_wre;
            m_adr_d = f_adr;
            m_dto_d = f_dto;
            lst_d   = 1'b0;
        end else if (grant_g) begin
            m_stb_d = 1'b1;
            m_wre_d = g_wre;
            m_adr_d = g_adr;
            m_dto_d = g_dto;
            lst_d   = 1'b1;
        end
        if (done && (state_q == BUSF)) begin
            m_stb_d = 1'b0;
            f_ack_d = 1'b1;
            f_err_d = !m_ack;
            f_dti_d = m_ack ? m_dti : '0;
        end
        if (done && (state_q == BUSG)) begin
            m_stb_d = 1'b0;
            g_ack_d = 1'b1;
            g_err_d = !m_ack;
            g_dti_d = m_ack ? m_dti : '0;
        end
    end

endmodule

// File: tb/tb_dcpu16_busarb.sv
// Directed self-checking bench for dcpu16_busarb (TOUT=4 instance).
module tb_dcpu16_busarb;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_stb, f_wre, g_stb, g_wre, m_ack;
    logic [15:0] f_adr, f_dto, g_adr, g_dto, m_dti;
    logic [15:0] f_dti, g_dti, m_adr, m_dto;
    logic        f_ack, f_err, g_ack, g_err, m_stb, m_wre;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    dcpu16_busarb #(
        .TOUT(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .f_stb(f_stb),
        .f_wre(f_wre),
        .f_adr(f_adr),
        .f_dto(f_dto),
        .f_dti(f_dti),
        .f_ack(f_ack),
        .f_err(f_err),
        .g_stb(g_stb),
        .g_wre(g_wre),
        .g_adr(g_adr),
        .g_dto(g_dto),
        .g_dti(g_dti),
        .g_ack(g_ack),
        .g_err(g_err),
        .m_stb(m_stb),
        .m_wre(m_wre),
        .m_adr(m_adr),
        .m_dto(m_dto),
        .m_dti(m_dti),
        .m_ack(m_ack)
    );

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        f_stb = 1'b0; f_wre = 1'b0; f_adr = 16'h0; f_dto = 16'h0;
        g_stb = 1'b0; g_wre = 1'b0; g_adr = 16'h0; g_dto = 16'h0;
        m_ack = 1'b0; m_dti = 16'h0;
    endtask

    initial begin
        // Reset with every input high
        rst = 1'b1;
        f_stb = 1'b1; f_wre = 1'b1; f_adr = 16'hFFFF; f_dto = 16'hFFFF;
        g_stb = 1'b1; g_wre = 1'b1; g_adr = 16'hFFFF; g_dto = 16'hFFFF;
        m_ack = 1'b1; m_dti = 16'hFFFF;
        tick();
        tick();
        chk1 ("rst_m_stb", m_stb, 1'b0);
        chk1 ("rst_m_wre", m_wre, 1'b0);
        chk16("rst_m_adr", m_adr, 16'h0);
        chk16("rst_m_dto", m_dto, 16'h0);
        chk1 ("rst_f_ack", f_ack, 1'b0);
        chk1 ("rst_g_ack", g_ack, 1'b0);
        chk1 ("rst_f_err", f_err, 1'b0);
        chk1 ("rst_g_err", g_err, 1'b0);
        chk16("rst_f_dti", f_dti, 16'h0);
        chk16("rst_g_dti", g_dti, 16'h0);
        rst = 1'b0;
        idle_inputs();
        tick();
        chk1("rst_after_m_stb", m_stb, 1'b0);

        // Single fetch, memory acks in the first strobe cycle
        f_stb = 1'b1; f_adr = 16'h0100;
        tick();
        chk1 ("sf_m_stb", m_stb, 1'b1);
        chk16("sf_m_adr", m_adr, 16'h0100);
        chk1 ("sf_m_wre", m_wre, 1'b0);
        chk1 ("sf_f_ack_early", f_ack, 1'b0);
        m_ack = 1'b1; m_dti = 16'h7C01;
        tick();
        chk1 ("sf_f_ack", f_ack, 1'b1);
        chk16("sf_f_dti", f_dti, 16'h7C01);
        chk1 ("sf_f_err", f_err, 1'b0);
        chk1 ("sf_m_stb_drop", m_stb, 1'b0);
        chk1 ("sf_g_ack", g_ack, 1'b0);
        f_stb = 1'b0; m_ack = 1'b0; m_dti = 16'h0;
        tick();
        chk1 ("sf_f_ack_pulse", f_ack, 1'b0);
        chk16("sf_f_dti_hold", f_dti, 16'h7C01);
        chk1 ("sf_m_stb_idle", m_stb, 1'b0);

        // Spurious ack while idle
        m_ack = 1'b1; m_dti = 16'h1234;
        tick();
        chk1 ("sp_f_ack", f_ack, 1'b0);
        chk1 ("sp_g_ack", g_ack, 1'b0);
        chk16("sp_f_dti", f_dti, 16'h7C01);
        chk1 ("sp_m_stb", m_stb, 1'b0);
        m_ack = 1'b0;

        // Tie from reset: grant order F, G, F, G
        rst = 1'b1;
        tick();
        rst = 1'b0;
        f_stb = 1'b1; f_adr = 16'h1111;
        g_stb = 1'b1; g_adr = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1 ("rr_m_stb", m_stb, 1'b1);
            chk16("rr_m_adr", m_adr, (i % 2 == 0) ? 16'h1111 : 16'h2222);
            m_ack = 1'b1; m_dti = 16'hA000 + 16'(i);
            tick();
            chk1("rr_f_ack", f_ack, (i % 2 == 0));
            chk1("rr_g_ack", g_ack, (i % 2 == 1));
            m_ack = 1'b0;
        end
        chk16("rr_f_dti", f_dti, 16'hA002);
        chk16("rr_g_dti", g_dti, 16'hA003);
        idle_inputs();
        tick();

        // Data write, three wait states; ack lands on the watchdog expiry cycle
        g_stb = 1'b1; g_wre = 1'b1; g_adr = 16'h8000; g_dto = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1 ("dw_m_stb", m_stb, 1'b1);
            chk1 ("dw_m_wre", m_wre, 1'b1);
            chk16("dw_m_dto", m_dto, 16'hBEEF);
            chk16("dw_m_adr", m_adr, 16'h8000);
            chk1 ("dw_g_ack_early", g_ack, 1'b0);
        end
        m_ack = 1'b1; m_dti = 16'h5A5A;
        tick();
        chk1 ("dw_g_ack", g_ack, 1'b1);
        chk1 ("dw_g_err", g_err, 1'b0);
        chk16("dw_g_dti", g_dti, 16'h5A5A);
        chk1 ("dw_m_stb_drop", m_stb, 1'b0);
        idle_inputs();
        tick();
        chk1("dw_g_ack_pulse", g_ack, 1'b0);

        // Fetch timeout: no ack, error ack four edges after strobe rises
        f_stb = 1'b1; f_adr = 16'h0200;
        tick();
        chk1("to_m_stb_rise", m_stb, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("to_m_stb_hold", m_stb, 1'b1);
            chk1("to_f_ack_early", f_ack, 1'b0);
        end
        tick();
        chk1 ("to_f_ack", f_ack, 1'b1);
        chk1 ("to_f_err", f_err, 1'b1);
        chk16("to_f_dti", f_dti, 16'h0000);
        chk1 ("to_m_stb_drop", m_stb, 1'b0);
        f_stb = 1'b0;
        tick();
        chk1("to_f_err_pulse", f_err, 1'b0);
        chk1("to_m_stb_idle", m_stb, 1'b0);

        // Fetch with ack on the expiry cycle: ack wins, no error
        f_stb = 1'b1; f_adr = 16'h0204;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        chk1("te_m_stb", m_stb, 1'b1);
        m_ack = 1'b1; m_dti = 16'hCAFE;
        tick();
        chk1 ("te_f_ack", f_ack, 1'b1);
        chk1 ("te_f_err", f_err, 1'b0);
        chk16("te_f_dti", f_dti, 16'hCAFE);
        idle_inputs();
        tick();

        // Reset two cycles into a wait-stated read; a late ack is ignored
        f_stb = 1'b1; f_adr = 16'h0300;
        tick();
        chk1("mr_m_stb", m_stb, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        chk1 ("mr_m_stb_drop", m_stb, 1'b0);
        chk1 ("mr_f_ack", f_ack, 1'b0);
        chk16("mr_m_adr", m_adr, 16'h0);
        chk16("mr_f_dti", f_dti, 16'h0);
        rst = 1'b0; f_stb = 1'b0;
        m_ack = 1'b1; m_dti = 16'h4444;
        tick();
        chk1 ("mr_late_f_ack", f_ack, 1'b0);
        chk1 ("mr_late_m_stb", m_stb, 1'b0);
        chk16("mr_late_f_dti", f_dti, 16'h0);
        m_ack = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
